// File: rtl/freq_div_cfg_ctrl.sv
// Configuration controller for the Frequency_Divider: round-robin arbitration of two
// ratio requesters, then a quiesce -> load -> settle sequence on the divider pins.
module freq_div_cfg_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int LOAD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_run,
  input  logic                  i_req0_valid,
  input  logic [DATA_WIDTH-1:0] i_req0_ratio,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic [DATA_WIDTH-1:0] i_req1_ratio,
  output logic                  o_req1_ready,
  output logic [DATA_WIDTH-1:0] o_div_din,
  output logic                  o_div_config,
  output logic                  o_div_enable,
  output logic                  o_busy,
  output logic                  o_cfg_done,
  output logic                  o_cfg_err,
  output logic                  o_grant_id,
  output logic [DATA_WIDTH-1:0] o_cur_ratio
);

  localparam int CMAX = (LOAD_CYCLES > SETTLE_CYCLES) ? LOAD_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_QUIESCE, S_LOAD, S_SETTLE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_din;
  logic [DATA_WIDTH-1:0] r_cur_ratio;
  logic                  r_winner;
  logic                  r_last;
  logic                  r_configured;
  logic                  r_cfg_done;
  logic                  r_cfg_err;
  logic                  r_grant_id;

  logic                  w_idle;
  logic                  w_win;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_ratio;
  logic                  w_ratio_ok;
  logic                  w_fin;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    w_idle = (r_state == S_IDLE);
    if (i_req0_valid && i_req1_valid) w_win = ~r_last;
    else                              w_win = i_req1_valid;
    w_accept   = w_idle && (i_req0_valid || i_req1_valid);
    w_ratio    = w_win ? i_req1_ratio : i_req0_ratio;
    w_ratio_ok = (w_ratio > DATA_WIDTH'(1));
  end

  assign o_req0_ready = w_accept && !w_win;
  assign o_req1_ready = w_accept &&  w_win;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The shared counter is reloaded on entry to LOAD and SETTLE and counts down to 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_ratio_ok) w_state_nxt = S_QUIESCE;
      end
      S_QUIESCE: begin
        w_state_nxt = S_LOAD;
        w_cnt_nxt   = CW'(LOAD_CYCLES - 1);
      end
      S_LOAD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = CW'(SETTLE_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_fin       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_din        <= '0;
      r_cur_ratio  <= '0;
      r_winner     <= 1'b0;
      r_last       <= 1'b1;
      r_configured <= 1'b0;
      r_cfg_done   <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_grant_id   <= 1'b0;
    end else begin
      r_cfg_done <= 1'b0;
      r_cfg_err  <= 1'b0;
      if (w_accept) begin
        r_last <= w_win;
        if (w_ratio_ok) begin
          r_din    <= w_ratio;
          r_winner <= w_win;
        end else begin
          // Rejected ratios never reach the divider; only the error is reported.
          r_cfg_err  <= 1'b1;
          r_grant_id <= w_win;
        end
      end
      if (w_fin) begin
        r_cur_ratio  <= r_din;
        r_configured <= 1'b1;
        r_cfg_done   <= 1'b1;
        r_grant_id   <= r_winner;
      end
    end
  end

  assign o_div_din    = r_din;
  assign o_div_config = (r_state == S_LOAD);
  assign o_div_enable = w_idle && i_run && r_configured;
  assign o_busy       = !w_idle;
  assign o_cfg_done   = r_cfg_done;
  assign o_cfg_err    = r_cfg_err;
  assign o_grant_id   = r_grant_id;
  assign o_cur_ratio  = r_cur_ratio;

endmodule

// File: tb/tb_freq_div_cfg_ctrl.sv
// Directed bench for freq_div_cfg_ctrl: stimulus driven and outputs sampled on the
// falling edge; k counts cycles after the accepting rising edge.
module tb_freq_div_cfg_ctrl;
  logic        clk = 1'b0;
  logic        i_reset, i_run;
  logic        i_req0_valid, i_req1_valid;
  logic [31:0] i_req0_ratio, i_req1_ratio;
  logic        o_req0_ready, o_req1_ready;
  logic [31:0] o_div_din, o_cur_ratio;
  logic        o_div_config, o_div_enable, o_busy, o_cfg_done, o_cfg_err, o_grant_id;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  freq_div_cfg_ctrl #(.DATA_WIDTH(32), .LOAD_CYCLES(2), .SETTLE_CYCLES(1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_run(i_run),
    .i_req0_valid(i_req0_valid), .i_req0_ratio(i_req0_ratio), .o_req0_ready(o_req0_ready),
    .i_req1_valid(i_req1_valid), .i_req1_ratio(i_req1_ratio), .o_req1_ready(o_req1_ready),
    .o_div_din(o_div_din), .o_div_config(o_div_config), .o_div_enable(o_div_enable),
    .o_busy(o_busy), .o_cfg_done(o_cfg_done), .o_cfg_err(o_cfg_err),
    .o_grant_id(o_grant_id), .o_cur_ratio(o_cur_ratio));

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_run = 1'b0;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_req0_ratio = '0; i_req1_ratio = '0;
    step(); step();
    checks++; if (o_div_din !== 32'd0 || o_cur_ratio !== 32'd0) begin failures++;
      $display("FAIL reset_data din=%0d cur=%0d exp=0", o_div_din, o_cur_ratio); end
    checks++; if ({o_div_config, o_div_enable, o_busy, o_cfg_done, o_cfg_err, o_grant_id,
                   o_req0_ready, o_req1_ready} !== 8'b0) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=00000000", {o_div_config, o_div_enable, o_busy,
               o_cfg_done, o_cfg_err, o_grant_id, o_req0_ready, o_req1_ready}); end
    i_reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    i_run = 1'b1;
    repeat (3) step();
    checks++; if (o_div_enable !== 1'b0 || o_cur_ratio !== 32'd0) begin failures++;
      $display("FAIL unconfigured en=%b cur=%0d exp en=0 cur=0", o_div_enable, o_cur_ratio); end
    i_req0_ratio = 32'd6; i_req0_valid = 1'b1;
    #1;
    checks++; if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin failures++;
      $display("FAIL basic_ready got=%b%b exp=10", o_req0_ready, o_req1_ready); end
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) i_req0_valid = 1'b0;
      checks++; if (o_div_config !== 1'((k == 2) || (k == 3))) begin failures++;
        $display("FAIL basic_config k=%0d got=%b", k, o_div_config); end
      checks++; if (o_div_enable !== 1'(k >= 5)) begin failures++;
        $display("FAIL basic_enable k=%0d got=%b", k, o_div_enable); end
      checks++; if (o_busy !== 1'(k <= 4) || o_cfg_done !== 1'(k == 5)) begin failures++;
        $display("FAIL basic_busy_done k=%0d got=%b%b", k, o_busy, o_cfg_done); end
      if (k == 2) begin
        checks++; if (o_div_din !== 32'd6) begin failures++;
          $display("FAIL basic_din got=%0d exp=6", o_div_din); end
      end
      if (k == 5) begin
        checks++; if (o_cur_ratio !== 32'd6 || o_grant_id !== 1'b0) begin failures++;
          $display("FAIL basic_done cur=%0d gid=%b exp cur=6 gid=0", o_cur_ratio, o_grant_id); end
      end
    end
  endtask

  task automatic test_reject();
    i_req1_ratio = 32'd1; i_req1_valid = 1'b1;
    #1;
    checks++; if (o_req1_ready !== 1'b1) begin failures++;
      $display("FAIL rej_ready1 got=%b exp=1", o_req1_ready); end
    step();
    i_req1_valid = 1'b0;
    checks++; if (o_cfg_err !== 1'b1 || o_grant_id !== 1'b1) begin failures++;
      $display("FAIL rej1_err err=%b gid=%b exp err=1 gid=1", o_cfg_err, o_grant_id); end
    checks++; if (o_cur_ratio !== 32'd6 || o_div_din !== 32'd6) begin failures++;
      $display("FAIL rej1_ratio cur=%0d din=%0d exp=6", o_cur_ratio, o_div_din); end
    checks++; if (o_div_config !== 1'b0 || o_div_enable !== 1'b1 || o_busy !== 1'b0) begin
      failures++; $display("FAIL rej1_pins cfg=%b en=%b busy=%b exp 0 1 0",
                           o_div_config, o_div_enable, o_busy); end
    // second rejected acceptance in the error cycle itself
    i_req0_ratio = 32'd0; i_req0_valid = 1'b1;
    #1;
    checks++; if (o_req0_ready !== 1'b1) begin failures++;
      $display("FAIL rej_ready0 got=%b exp=1", o_req0_ready); end
    step();
    i_req0_valid = 1'b0;
    checks++; if (o_cfg_err !== 1'b1 || o_grant_id !== 1'b0 || o_cur_ratio !== 32'd6) begin
      failures++; $display("FAIL rej0_err err=%b gid=%b cur=%0d exp 1 0 6",
                           o_cfg_err, o_grant_id, o_cur_ratio); end
    step();
    checks++; if (o_cfg_err !== 1'b0 || o_div_config !== 1'b0 || o_div_enable !== 1'b1) begin
      failures++; $display("FAIL rej_after err=%b cfg=%b en=%b exp 0 0 1",
                           o_cfg_err, o_div_config, o_div_enable); end
  endtask

  task automatic test_arbitration();
    i_req0_ratio = 32'd4; i_req1_ratio = 32'd8;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    #1;
    checks++; if (o_req1_ready !== 1'b1 || o_req0_ready !== 1'b0) begin failures++;
      $display("FAIL arb_tie got r0=%b r1=%b exp r0=0 r1=1", o_req0_ready, o_req1_ready); end
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) i_req1_valid = 1'b0;
      checks++; if (o_div_enable !== 1'(k == 5) || o_cfg_done !== 1'(k == 5)) begin
        failures++; $display("FAIL arb1_en_done k=%0d got=%b%b", k, o_div_enable, o_cfg_done); end
      checks++; if (o_req0_ready !== 1'(k == 5)) begin failures++;
        $display("FAIL arb_wait_ready0 k=%0d got=%b", k, o_req0_ready); end
      if (k == 5) begin
        checks++; if (o_grant_id !== 1'b1 || o_cur_ratio !== 32'd8) begin failures++;
          $display("FAIL arb1_done gid=%b cur=%0d exp gid=1 cur=8", o_grant_id, o_cur_ratio); end
      end
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) i_req0_valid = 1'b0;
      checks++; if (o_div_enable !== 1'(k == 5) || o_div_config !== 1'((k == 2) || (k == 3))) begin
        failures++; $display("FAIL arb2_pins k=%0d en=%b cfg=%b", k, o_div_enable, o_div_config); end
      if (k == 2) begin
        checks++; if (o_div_din !== 32'd4) begin failures++;
          $display("FAIL arb2_din got=%0d exp=4", o_div_din); end
      end
      if (k == 5) begin
        checks++; if (o_cfg_done !== 1'b1 || o_grant_id !== 1'b0 || o_cur_ratio !== 32'd4) begin
          failures++; $display("FAIL arb2_done done=%b gid=%b cur=%0d exp 1 0 4",
                               o_cfg_done, o_grant_id, o_cur_ratio); end
      end
    end
  endtask

  task automatic test_run_gating();
    i_req0_ratio = 32'd2; i_req0_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) i_req0_valid = 1'b0;
      checks++; if (o_div_enable !== 1'(k == 5)) begin failures++;
        $display("FAIL run_hold_en k=%0d got=%b", k, o_div_enable); end
      if (k == 5) begin
        checks++; if (o_cfg_done !== 1'b1 || o_cur_ratio !== 32'd2) begin failures++;
          $display("FAIL run_hold_done done=%b cur=%0d exp 1 2", o_cfg_done, o_cur_ratio); end
      end
    end
    i_req0_ratio = 32'd9; i_req0_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) i_req0_valid = 1'b0;
      checks++; if (o_div_enable !== 1'b0) begin failures++;
        $display("FAIL run_drop_en k=%0d got=%b exp=0", k, o_div_enable); end
      if (k == 2) i_run = 1'b0;
      if (k == 5) begin
        checks++; if (o_cfg_done !== 1'b1 || o_cur_ratio !== 32'd9) begin failures++;
          $display("FAIL run_drop_done done=%b cur=%0d exp 1 9", o_cfg_done, o_cur_ratio); end
      end
    end
    i_run = 1'b1;
    #1;
    checks++; if (o_div_enable !== 1'b1) begin failures++;
      $display("FAIL run_restore_en got=%b exp=1", o_div_enable); end
  endtask

  task automatic test_reset_mid();
    i_req0_ratio = 32'd7; i_req0_valid = 1'b1;
    step();
    i_req0_valid = 1'b0;
    step();
    checks++; if (o_div_config !== 1'b1) begin failures++;
      $display("FAIL rstmid_load cfg=%b exp=1", o_div_config); end
    i_reset = 1'b1;
    #1;
    checks++; if (o_div_config !== 1'b0 || o_div_enable !== 1'b0 || o_busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_pins cfg=%b en=%b busy=%b exp 000",
                           o_div_config, o_div_enable, o_busy); end
    checks++; if (o_cur_ratio !== 32'd0 || o_div_din !== 32'd0) begin failures++;
      $display("FAIL rstmid_data cur=%0d din=%0d exp=0", o_cur_ratio, o_div_din); end
    step();
    i_reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++; if (o_cfg_done !== 1'b0 || o_div_enable !== 1'b0 || o_busy !== 1'b0) begin
        failures++; $display("FAIL rstmid_after k=%0d done=%b en=%b busy=%b exp 000",
                             k, o_cfg_done, o_div_enable, o_busy); end
    end
  endtask

  task automatic test_back_to_back();
    i_req0_ratio = 32'd5; i_req0_valid = 1'b1;
    #1;
    checks++; if (o_req0_ready !== 1'b1) begin failures++;
      $display("FAIL b2b_ready_first got=%b exp=1", o_req0_ready); end
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) i_req0_ratio = 32'd3;
      checks++; if (o_req0_ready !== 1'(k == 5) || o_cfg_done !== 1'(k == 5)) begin failures++;
        $display("FAIL b2b_hold k=%0d ready=%b done=%b", k, o_req0_ready, o_cfg_done); end
      if (k == 5) begin
        checks++; if (o_cur_ratio !== 32'd5 || o_div_enable !== 1'b1) begin failures++;
          $display("FAIL b2b_first cur=%0d en=%b exp 5 1", o_cur_ratio, o_div_enable); end
      end
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) i_req0_valid = 1'b0;
      checks++; if (o_cfg_done !== 1'(k == 5)) begin failures++;
        $display("FAIL b2b_second_done k=%0d got=%b", k, o_cfg_done); end
      if (k == 5) begin
        checks++; if (o_cur_ratio !== 32'd3 || o_grant_id !== 1'b0 || o_div_enable !== 1'b1) begin
          failures++; $display("FAIL b2b_second cur=%0d gid=%b en=%b exp 3 0 1",
                               o_cur_ratio, o_grant_id, o_div_enable); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_arbitration();
    test_run_gating();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/freq_div_cfg_ctrl.md
# freq_div_cfg_ctrl

Configuration controller for the calculator's Frequency_Divider. Accepts division-ratio requests from two requesters (index 0: calculator core, index 1: debug host) over valid/ready handshakes, arbitrates round-robin, and drives the divider's `din`/`configDiv`/`enable` pins through a fixed quiesce → load → settle sequence so the divider is never reconfigured while running. Sits between the requesters and the divider instance and is the divider's only driver.

## Interface
- `DATA_WIDTH`, 32: ratio width, matches the divider `din`.
- `LOAD_CYCLES`, 2: cycles `div_config` is held high (≥1).
- `SETTLE_CYCLES`, 1: cycles with config and enable both low after load (≥1).
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `run` in 1: global run request; the divider is enabled only when `run`=1 and a valid ratio has been loaded.
- `req0_valid` in 1 / `req0_ratio` in DATA_WIDTH / `req0_ready` out 1: requester 0 handshake.
- `req1_valid` in 1 / `req1_ratio` in DATA_WIDTH / `req1_ready` out 1: requester 1 handshake.
- `div_din` out DATA_WIDTH: to divider `din`.
- `div_config` out 1: to divider `configDiv`.
- `div_enable` out 1: to divider `enable`.
- `busy` out 1: high in any state other than IDLE.
- `cfg_done` out 1: one-cycle pulse, configuration completed.
- `cfg_err` out 1: one-cycle pulse, request rejected.
- `grant_id` out 1: requester index of the last done/err event.
- `cur_ratio` out DATA_WIDTH: ratio currently loaded in the divider.

## Operation
- States: IDLE, QUIESCE, LOAD, SETTLE. Reset → IDLE.
- Reset values: all outputs 0; the `configured` flag is 0; the round-robin pointer gives priority to requester 0; the latched ratio is 0.
- IDLE: `reqN_ready` is combinational. It is high only for the arbitration winner, and only when that requester's valid is high. No ready is issued in any other state.
- Arbitration: if a single requester is valid, it wins. If both are valid, the one not granted last wins. The pointer updates on every acceptance, including rejected ones.
- Transfer occurs on the edge where valid & ready is 1. The ratio is latched into `div_din` on that edge, and the winner index is latched.
- Ratio check: a ratio below 2 (0 or 1) is rejected.
  - `cfg_err`=1 and `grant_id`=winner in the next cycle.
  - State stays IDLE; `div_din` and `cur_ratio` are unchanged, because the latch is suppressed.
  - The divider is not touched.
- Ratio ≥2: IDLE → QUIESCE (1 cycle) → LOAD (LOAD_CYCLES cycles) → SETTLE (SETTLE_CYCLES cycles) → IDLE.
- On SETTLE exit:
  - `cur_ratio` ← latched ratio.
  - `configured` ← 1.
  - `cfg_done`=1 and `grant_id`=winner for the first IDLE cycle.
- Output decode:
  - `div_enable`=`run` & `configured` in IDLE, 0 in all other states.
  - `div_config`=1 only in LOAD.
  - `div_din` holds the latched ratio at all times.
  - All three are decoded from registered state only; there is no input-to-output path except `run` in IDLE.
- A single cycle-counter sized to max(LOAD_CYCLES, SETTLE_CYCLES) is reloaded on each state entry.
- `run` changes during QUIESCE/LOAD/SETTLE do not alter the sequence. Its value takes effect in IDLE.
- Requests held valid while the controller is busy wait. They are not dropped, and their ratio must be held stable by the requester until accepted.

## Timing
- Acceptance at edge E. The cycle numbers below assume default parameters.
  - Cycle E+1: QUIESCE (enable 0, config 0).
  - E+2..E+3: LOAD (config 1).
  - E+4: SETTLE.
  - E+5: IDLE with `cfg_done`=1; `div_enable` returns to `run`.
- Busy window = 1+LOAD_CYCLES+SETTLE_CYCLES cycles.
- A new acceptance is allowed in the same IDLE cycle as `cfg_done` or `cfg_err`. This gives back-to-back throughput of one configuration per 1+LOAD_CYCLES+SETTLE_CYCLES+1 cycles.
- `cfg_err` follows a rejected acceptance by exactly 1 cycle. A second acceptance may occur in that cycle.
- Asynchronous reset mid-sequence:
  - `div_config` and `div_enable` drop immediately, `configured`=0, and the pending request is lost.
  - No `cfg_done` is produced.
  - `div_enable` stays 0 until a new configuration completes.

## Test plan
- Reset, then `run`=1 with no request → `div_enable` stays 0 and `cur_ratio`=0. Then req0 ratio 6 → `div_config` high 2 cycles with `div_din`=6, `cfg_done` at E+5, `cur_ratio`=6, `grant_id`=0, `div_enable`=1.
- Both requesters valid in IDLE (req0=4, req1=8), starting from a pointer with last grant = 0 → req1 accepted first, then req0; final `cur_ratio`=4. `grant_id` goes 1 then 0. `div_enable` is 0 throughout each busy window.
- req1 ratio 1 while `cur_ratio`=6 → `cfg_err` pulse 1 cycle later, `grant_id`=1, `cur_ratio`=6, `div_config` never asserts, `div_enable` stays 1.
- Request ratio 2 while `run`=1 → `div_enable` falls at E+1 and rises at E+5. Deasserting `run` during LOAD → `div_enable`=0 at E+5.
- Assert `reset` during LOAD → `div_config`=0 and `div_enable`=0 before the next edge, `busy`=0, `cur_ratio`=0, no `cfg_done`.
- req0 held valid with ratio 3 while the controller is busy with ratio 5 → `req0_ready` stays 0 until the `cfg_done` cycle, accepted there; second `cfg_done` 5 cycles later with `cur_ratio`=3.
